// File: rtl/bp_update_sched.sv
// bp_update_sched: shares the predictor's single index port between fetch lookups and queued commit updates.
// Resolved branches wait in a FIFO and drain in commit order, with a starvation guard against continuous fetch.
module bp_update_sched #(
    parameter int LOCAL_WIDTH  = 10,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     lookup_valid,
    input  logic [LOCAL_WIDTH-1:0]   lookup_addr,
    output logic                     lookup_grant,
    output logic                     lookup_pred,
    input  logic                     resolve_valid,
    input  logic [LOCAL_WIDTH-1:0]   resolve_addr,
    input  logic                     resolve_taken,
    output logic                     resolve_ready,
    output logic [LOCAL_WIDTH-1:0]   pred_addr,
    output logic                     pred_transition,
    output logic                     pred_branch,
    input  logic                     pred_in,
    output logic [$clog2(DEPTH):0]   queue_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [LOCAL_WIDTH-1:0] addr_q [DEPTH];
    logic                   taken_q [DEPTH];
    logic [PW-1:0]          head_q, tail_q;
    logic [CW-1:0]          count_q, count_d;
    logic [SW-1:0]          starve_q, starve_d;
    logic                   full, empty, update_sel, enq, deq;

    always_comb begin
        full            = count_q == CW'(DEPTH);
        empty           = count_q == '0;
        update_sel      = !empty && (!lookup_valid || full || starve_q >= SW'(STARVE_LIMIT));
        deq             = update_sel && rdy_in;
        // A full FIFO refuses input even when it drains this cycle.
        enq             = rdy_in && resolve_valid && !full;
        lookup_grant    = lookup_valid && !update_sel && rdy_in;
        lookup_pred     = pred_in;
        resolve_ready   = !full;
        pred_addr       = update_sel ? addr_q[head_q] : lookup_addr;
        pred_branch     = taken_q[head_q];
        pred_transition = deq;
        queue_count     = count_q;
        count_d         = (enq && !deq) ? count_q + 1'b1 : (deq && !enq) ? count_q - 1'b1 : count_q;
        starve_d        = (deq || empty) ? '0
                        : (lookup_grant && starve_q < SW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
    end

    always_ff @(posedge clk_in) begin
        if (enq) begin
            addr_q[tail_q]  <= resolve_addr;
            taken_q[tail_q] <= resolve_taken;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            head_q   <= deq ? head_q + 1'b1 : head_q;
            tail_q   <= enq ? tail_q + 1'b1 : tail_q;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end
endmodule

// File: tb/tb_bp_update_sched.sv
// tb_bp_update_sched: directed scenario tasks for the predictor port scheduler.
module tb_bp_update_sched;
    logic       clk_in = 1'b0, rst_in, rdy_in;
    logic       lookup_valid, lookup_grant, lookup_pred;
    logic [9:0] lookup_addr, resolve_addr, pred_addr;
    logic       resolve_valid, resolve_taken, resolve_ready;
    logic       pred_transition, pred_branch, pred_in;
    logic [2:0] queue_count;
    int         checks = 0, errors = 0;

    function automatic logic pm(input logic [9:0] a);
        return a[0] ^ a[4] ^ a[9];
    endfunction

    assign pred_in = pm(pred_addr);
    always #5 clk_in = ~clk_in;

    bp_update_sched dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
        .lookup_grant(lookup_grant), .lookup_pred(lookup_pred),
        .resolve_valid(resolve_valid), .resolve_addr(resolve_addr),
        .resolve_taken(resolve_taken), .resolve_ready(resolve_ready),
        .pred_addr(pred_addr), .pred_transition(pred_transition),
        .pred_branch(pred_branch), .pred_in(pred_in), .queue_count(queue_count)
    );

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset;
        rst_in = 1'b0; rdy_in = 1'b1; lookup_valid = 1'b0; lookup_addr = 10'h000;
        resolve_valid = 1'b0; resolve_addr = 10'h000; resolve_taken = 1'b0;
        #2;
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", queue_count); end
        checks++; if (resolve_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", resolve_ready); end
        checks++; if (pred_transition !== 1'b0) begin errors++; $display("FAIL rst_trans got %b exp 0", pred_transition); end
        #11 rst_in = 1'b1;
        tick();
        lookup_valid = 1'b1; lookup_addr = 10'h001; resolve_valid = 1'b1; resolve_addr = 10'h111; resolve_taken = 1'b1;
        tick(); tick(); tick();
        resolve_valid = 1'b0;
        #1;
        checks++; if (queue_count !== 3'd3) begin errors++; $display("FAIL pre_rst_count got %0d exp 3", queue_count); end
        #2 rst_in = 1'b0;
        #1;
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL async_rst_count got %0d exp 0", queue_count); end
        checks++; if (resolve_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready got %b exp 1", resolve_ready); end
        checks++; if (lookup_grant !== 1'b1) begin errors++; $display("FAIL async_rst_grant got %b exp 1", lookup_grant); end
        rst_in = 1'b1; lookup_valid = 1'b0;
        tick();
        #1;
        checks++; if (pred_transition !== 1'b0) begin errors++; $display("FAIL post_rst_trans got %b exp 0", pred_transition); end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL post_rst_count got %0d exp 0", queue_count); end
        tick();
    endtask

    task automatic test_idle_drain;
        lookup_valid = 1'b0; resolve_valid = 1'b1; resolve_addr = 10'h005; resolve_taken = 1'b1;
        #1;
        checks++; if (pred_transition !== 1'b0) begin errors++; $display("FAIL idle_empty_trans got %b exp 0", pred_transition); end
        tick();
        resolve_addr = 10'h3FF; resolve_taken = 1'b0;
        #1;
        checks++; if ({pred_addr, pred_branch, pred_transition} !== {10'h005, 1'b1, 1'b1})
            begin errors++; $display("FAIL idle_first got %h/%b/%b exp 005/1/1", pred_addr, pred_branch, pred_transition); end
        tick();
        resolve_valid = 1'b0;
        #1;
        checks++; if ({pred_addr, pred_branch, pred_transition} !== {10'h3FF, 1'b0, 1'b1})
            begin errors++; $display("FAIL idle_second got %h/%b/%b exp 3ff/0/1", pred_addr, pred_branch, pred_transition); end
        tick();
        checks++; if (queue_count !== 3'd0 || pred_transition !== 1'b0)
            begin errors++; $display("FAIL idle_done got %0d/%b exp 0/0", queue_count, pred_transition); end
    endtask

    task automatic test_lookup_priority;
        lookup_valid = 1'b1; lookup_addr = 10'h010; resolve_valid = 1'b1; resolve_addr = 10'h123; resolve_taken = 1'b1;
        tick();
        resolve_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            checks++; if ({lookup_grant, pred_addr, pred_transition, lookup_pred} !== {1'b1, 10'h010, 1'b0, pm(10'h010)})
                begin errors++; $display("FAIL prio_grant%0d got %b/%h/%b/%b exp 1/010/0/%b", i, lookup_grant, pred_addr, pred_transition, lookup_pred, pm(10'h010)); end
            tick();
        end
        #1;
        checks++; if ({lookup_grant, pred_transition, pred_addr} !== {1'b0, 1'b1, 10'h123})
            begin errors++; $display("FAIL prio_forced got %b/%b/%h exp 0/1/123", lookup_grant, pred_transition, pred_addr); end
        tick();
        checks++; if (lookup_grant !== 1'b1 || queue_count !== 3'd0)
            begin errors++; $display("FAIL prio_resume got %b/%0d exp 1/0", lookup_grant, queue_count); end
    endtask

    task automatic test_full;
        logic [9:0] exp_a [4];
        exp_a[0] = 10'h201; exp_a[1] = 10'h202; exp_a[2] = 10'h203; exp_a[3] = 10'h0AA;
        lookup_valid = 1'b1; lookup_addr = 10'h020; resolve_valid = 1'b1; resolve_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            resolve_addr = 10'h200 + 10'(i);
            tick();
        end
        resolve_addr = 10'h0AA; resolve_taken = 1'b0;
        #1;
        checks++; if ({resolve_ready, queue_count, pred_transition, lookup_grant, pred_addr} !== {1'b0, 3'd4, 1'b1, 1'b0, 10'h200})
            begin errors++; $display("FAIL full_forced got %b/%0d/%b/%b/%h exp 0/4/1/0/200", resolve_ready, queue_count, pred_transition, lookup_grant, pred_addr); end
        tick();
        #1;
        checks++; if ({resolve_ready, queue_count, lookup_grant} !== {1'b1, 3'd3, 1'b1})
            begin errors++; $display("FAIL full_reopen got %b/%0d/%b exp 1/3/1", resolve_ready, queue_count, lookup_grant); end
        tick();
        resolve_valid = 1'b0; lookup_valid = 1'b0;
        #1;
        checks++; if (queue_count !== 3'd4) begin errors++; $display("FAIL full_refill got %0d exp 4", queue_count); end
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({pred_addr, pred_branch, pred_transition} !== {exp_a[i], i != 3, 1'b1})
                begin errors++; $display("FAIL full_order%0d got %h/%b/%b exp %h/%b/1", i, pred_addr, pred_branch, pred_transition, exp_a[i], i != 3); end
            tick();
        end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL full_drained got %0d exp 0", queue_count); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] exp_a [6];
        for (int i = 0; i < 6; i++) exp_a[i] = 10'h300 + 10'(i);
        lookup_valid = 1'b1; lookup_addr = 10'h030; resolve_valid = 1'b1; resolve_taken = 1'b0;
        resolve_addr = exp_a[0]; tick();
        resolve_addr = exp_a[1]; tick();
        lookup_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            resolve_addr = exp_a[i + 2];
            #1;
            checks++; if ({queue_count, pred_addr, pred_transition} !== {3'd2, exp_a[i], 1'b1})
                begin errors++; $display("FAIL simul%0d got %0d/%h/%b exp 2/%h/1", i, queue_count, pred_addr, pred_transition, exp_a[i]); end
            tick();
        end
        resolve_valid = 1'b0;
        for (int i = 4; i < 6; i++) begin
            #1;
            checks++; if (pred_addr !== exp_a[i]) begin errors++; $display("FAIL simul_tail%0d got %h exp %h", i, pred_addr, exp_a[i]); end
            tick();
        end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL simul_drained got %0d exp 0", queue_count); end
    endtask

    task automatic test_rdy_low;
        lookup_valid = 1'b1; lookup_addr = 10'h040; resolve_valid = 1'b1; resolve_taken = 1'b1;
        resolve_addr = 10'h0D0; tick();
        resolve_addr = 10'h0E0; tick();
        rdy_in = 1'b0; resolve_addr = 10'h0F0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({lookup_grant, pred_transition, queue_count, resolve_ready} !== {1'b0, 1'b0, 3'd2, 1'b1})
                begin errors++; $display("FAIL rdy_low%0d got %b/%b/%0d/%b exp 0/0/2/1", i, lookup_grant, pred_transition, queue_count, resolve_ready); end
            tick();
        end
        rdy_in = 1'b1; resolve_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            checks++; if ({lookup_grant, pred_transition} !== 2'b10)
                begin errors++; $display("FAIL rdy_resume%0d got %b/%b exp 1/0", i, lookup_grant, pred_transition); end
            tick();
        end
        #1;
        checks++; if ({lookup_grant, pred_transition, pred_addr} !== {1'b0, 1'b1, 10'h0D0})
            begin errors++; $display("FAIL rdy_forced got %b/%b/%h exp 0/1/0d0", lookup_grant, pred_transition, pred_addr); end
        tick();
        lookup_valid = 1'b0;
        #1;
        checks++; if ({pred_addr, pred_transition, queue_count} !== {10'h0E0, 1'b1, 3'd1})
            begin errors++; $display("FAIL rdy_last got %h/%b/%0d exp 0e0/1/1", pred_addr, pred_transition, queue_count); end
        tick();
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL rdy_drained got %0d exp 0", queue_count); end
    endtask

    initial begin
        test_reset();
        test_idle_drain();
        test_lookup_priority();
        test_full();
        test_back_to_back();
        test_rdy_low();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bp_update_sched.md
Name: bp_update_sched

Overview:
- Scheduler in front of the local-history branch predictor, whose single instr_addr port is shared between fetch lookups and commit-time counter updates.
- Buffers resolved branches from commit in a small FIFO.
- Each cycle, decides whether the predictor port serves a fetch lookup or drains one queued update, with a starvation guard so updates always make progress.
- Sits between IF/commit and the predictor instance.

Parameters:
LOCAL_WIDTH, 10, width of the predictor index (low instruction-address bits).
DEPTH, 4, update FIFO entries; power of two, >=2.
STARVE_LIMIT, 8, consecutive lookup-won cycles with a non-empty queue before the update is forced; >=1.

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  ready; low pauses all state changes and grants
lookup_valid  input  1  fetch requests a prediction this cycle
lookup_addr  input  LOCAL_WIDTH  fetch index
lookup_grant  output  1  lookup served this cycle; lookup_pred valid
lookup_pred  output  1  prediction for lookup_addr (1 = jump)
resolve_valid  input  1  commit delivers a resolved branch
resolve_addr  input  LOCAL_WIDTH  index of resolved branch
resolve_taken  input  1  actual outcome (1 = jumped)
resolve_ready  output  1  FIFO can accept this cycle
pred_addr  output  LOCAL_WIDTH  drives predictor instr_addr
pred_transition  output  1  drives predictor transition_signal
pred_branch  output  1  drives predictor branch
pred_in  input  1  predictor prediction output (combinational on pred_addr)
queue_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- State: FIFO storage of {addr, taken}; head/tail pointers $clog2(DEPTH) bits, wrapping modulo DEPTH; count register; starve counter of $clog2(STARVE_LIMIT+1) bits.
- rst_in low (async): pointers, count and starve cleared immediately; FIFO contents don't-care.
  - Outputs then: resolve_ready=1, queue_count=0, pred_transition=0, lookup_grant=lookup_valid&rdy_in.
- resolve_ready = (count != DEPTH), from registered count only. No enqueue into a full FIFO even if a dequeue happens the same cycle.
- Enqueue: rising edge with rdy_in & resolve_valid & resolve_ready; writes {resolve_addr, resolve_taken} at tail; tail++.
- update_sel (combinational) = (count != 0) & (~lookup_valid | count == DEPTH | starve >= STARVE_LIMIT).
- Port mux:
  - pred_addr = update_sel ? head.addr : lookup_addr.
  - pred_branch = head.taken.
  - pred_transition = update_sel & rdy_in.
- Dequeue: on a cycle with pred_transition=1, head++ at the edge.
- lookup_grant = lookup_valid & ~update_sel & rdy_in.
- lookup_pred = pred_in, passed through combinationally. Meaningful only when lookup_grant=1; fetch retries next cycle otherwise.
- Count: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither. Simultaneous enqueue and dequeue is legal whenever count was < DEPTH.
- Starve counter:
  - Cleared on dequeue, or whenever count == 0.
  - Otherwise +1 on each cycle with rdy_in & count != 0 & lookup_grant.
  - Saturates at STARVE_LIMIT.
- rdy_in low: no enqueue, dequeue, grant, or starve change; pred_transition=0; all registers hold.
- Updates are applied strictly in commit order. At most one counter update per cycle.
- Empty queue: lookup always owns the port; pred_addr = lookup_addr even when lookup_valid=0.
- Reset mid-operation discards queued updates. Predictor reset is handled separately at top level.

Test Plan:
- Reset: rst_in low mid-cycle with count=3 -> queue_count=0 and resolve_ready=1 asynchronously; pred_transition=0 after release.
- Idle drain: lookup_valid=0; enqueue addr 0x005 taken, then 0x3FF not-taken -> next two cycles pred_addr=0x005/pred_branch=1, then 0x3FF/0, each with pred_transition=1; queue_count returns to 0.
- Lookup priority: queue 1 entry, lookup_valid=1 continuously at 0x010 with STARVE_LIMIT=8 -> lookup_grant=1 and pred_addr=0x010 for 8 cycles. Cycle 9: update forced, lookup_grant=0, starve cleared. Cycle 10: grant resumes.
- Full: with lookup_valid=1, enqueue 4 entries -> resolve_ready=0 at count=4; update forced next cycle regardless of starve; resolve_valid held high is accepted only after count drops to 3.
- Simultaneous: count=2, enqueue and dequeue in the same cycle -> count stays 2; tail and head both advance; wrap from index 3 to 0 preserves FIFO order.
- rdy_in low for 3 cycles with count=2 and lookup_valid=1 -> no grant, no transition, count and starve frozen; behaviour resumes identically when rdy_in returns high.
